// File: rtl/game_pkg.sv
// Shared definitions for the whack game datapath.
//   game_state_e    : game FSM states
//   NO_BOX          : box address meaning "no contact / nothing lit"
//   ARM_RETRY_LIMIT : rejected LFSR samples tolerated before a target is forced
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_HIT = 3'd2,
    COOLDOWN = 3'd3,
    DONE     = 3'd4
  } game_state_e;

  localparam int NO_BOX          = 0;
  localparam int ARM_RETRY_LIMIT = 8;

endpackage

// File: rtl/sensor_contact_det.sv
// Sensor contact detector: two-flop synchroniser for the raw box address,
// followed by a hold register holding the previous synchronised value.
// A contact is reported for exactly one cycle when the synchronised address
// leaves zero, so a box that is held down produces a single contact.
// Ports:
//   CLOCK_50     in  system clock
//   reset        in  asynchronous, active-high
//   sensor_addr  in  raw box address, asynchronous to CLOCK_50
//   contact      out one-cycle contact strobe
//   contact_addr out synchronised box address carried by the contact
module sensor_contact_det #(
  parameter int ADDR_W = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sensor_addr,
  output logic              contact,
  output logic [ADDR_W-1:0] contact_addr
);

  logic [ADDR_W-1:0] sync1_q, sync1_d;
  logic [ADDR_W-1:0] sync2_q, sync2_d;
  logic [ADDR_W-1:0] hold_q,  hold_d;

  always_comb begin
    sync1_d = sensor_addr;
    sync2_d = sync1_q;
    hold_d  = sync2_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hold_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hold_q  <= hold_d;
    end
  end

  // Contact appears two edges after an input change; the game FSM registers
  // its reaction on the third edge.
  assign contact      = (sync2_q != '0) && (hold_q == '0);
  assign contact_addr = sync2_q;

endmodule

// File: rtl/whack_game_engine.sv
// Game datapath for the N-box whack game: picks targets from the LFSR, scores
// hits and misses with saturation, runs the countdown timer and the hit sound.
// Ports:
//   CLOCK_50, reset          clock; asynchronous active-high reset
//   start_game               level; rising edge starts a game from IDLE/DONE
//   sensor_addr              raw box address from read_sensor (async)
//   lfsr_value               free-running LFSR sample
//   target, target_valid     lit box (0 when none) and "waiting for a hit"
//   score, game_timer        running score, seconds remaining
//   game_over                high in DONE
//   hit_event, miss_event    one-cycle pulses
//   play_sound               audio trigger
//   state_dbg                current FSM state
// target/target_valid: target is meaningful only while target_valid is high;
// there is no ready, the player "accepts" it by hitting a box, and the pair is
// withdrawn (both low/zero) on the cycle after the hit, miss or game end.
module whack_game_engine
  import game_pkg::*;
#(
  parameter int NUM_BOXES     = 6,
  parameter int ADDR_W        = 3,
  parameter int SCORE_W       = 11,
  parameter int CLK_HZ        = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int TARGET_CYCLES = 75_000_000,
  parameter int COOLDOWN_CYC  = 5_000_000,
  parameter int SOUND_CYCLES  = 10_000_000,
  parameter int HIT_PTS       = 1,
  parameter int MISS_PTS      = 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_game,
  input  logic [ADDR_W-1:0]  sensor_addr,
  input  logic [ADDR_W-1:0]  lfsr_value,
  output logic [ADDR_W-1:0]  target,
  output logic               target_valid,
  output logic [SCORE_W-1:0] score,
  output logic [6:0]         game_timer,
  output logic               game_over,
  output logic               hit_event,
  output logic               miss_event,
  output logic               play_sound,
  output game_state_e        state_dbg
);

  localparam int PRESC_W = (CLK_HZ > 1)        ? $clog2(CLK_HZ)        : 1;
  localparam int TGT_W   = (TARGET_CYCLES > 1) ? $clog2(TARGET_CYCLES) : 1;
  localparam int CD_W    = (COOLDOWN_CYC > 1)  ? $clog2(COOLDOWN_CYC)  : 1;
  localparam int SND_W   = $clog2(SOUND_CYCLES + 1);
  localparam int RETRY_W = $clog2(ARM_RETRY_LIMIT);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [TGT_W-1:0]   TGT_LAST   = TGT_W'(TARGET_CYCLES - 1);
  localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_CYC - 1);
  localparam logic [SND_W-1:0]   SND_LOAD   = SND_W'(SOUND_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(ARM_RETRY_LIMIT - 1);
  localparam logic [6:0]         TIMER_INIT = 7'(GAME_SECONDS);
  localparam logic [ADDR_W-1:0]  NO_BOX_A   = ADDR_W'(NO_BOX);
  localparam logic [ADDR_W-1:0]  MAX_BOX    = ADDR_W'(NUM_BOXES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]   HIT_EXT    = (SCORE_W + 1)'(HIT_PTS);
  localparam logic [SCORE_W:0]   MISS_EXT   = (SCORE_W + 1)'(MISS_PTS);

  function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + HIT_EXT;
    if (sum > {1'b0, SCORE_MAX}) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sub_floor(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] diff;
    if ({1'b0, s} < MISS_EXT) return '0;
    diff = {1'b0, s} - MISS_EXT;
    return diff[SCORE_W-1:0];
  endfunction

  logic              contact;
  logic [ADDR_W-1:0] contact_addr;

  sensor_contact_det #(.ADDR_W(ADDR_W)) u_contact (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sensor_addr  (sensor_addr),
    .contact      (contact),
    .contact_addr (contact_addr)
  );

  game_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               target_valid_q, target_valid_d;
  logic [ADDR_W-1:0]  prev_target_q, prev_target_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [6:0]         timer_q, timer_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TGT_W-1:0]   tgt_cnt_q, tgt_cnt_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [SND_W-1:0]   snd_cnt_q, snd_cnt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               start_q, start_d;

  logic              start_rise;
  logic              cand_ok;
  logic [ADDR_W-1:0] forced_target;

  assign start_rise = start_game & ~start_q;
  assign cand_ok    = (lfsr_value != NO_BOX_A) && (lfsr_value <= MAX_BOX) &&
                      (lfsr_value != prev_target_q);
  // (prev % NUM_BOXES) + 1 without a divider: prev never exceeds NUM_BOXES.
  assign forced_target = (prev_target_q >= MAX_BOX) ? ADDR_W'(1)
                                                    : prev_target_q + ADDR_W'(1);

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    prev_target_d  = prev_target_q;
    score_d        = score_q;
    timer_d        = timer_q;
    presc_d        = presc_q;
    tgt_cnt_d      = tgt_cnt_q;
    cd_cnt_d       = cd_cnt_q;
    retry_d        = retry_q;
    snd_cnt_d      = (snd_cnt_q != '0) ? snd_cnt_q - SND_W'(1) : snd_cnt_q;
    hit_d          = 1'b0;
    miss_d         = 1'b0;
    start_d        = start_game;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = ARM;
          score_d = '0;
          timer_d = TIMER_INIT;
          presc_d = '0;
          retry_d = '0;
        end
      end
      ARM: begin
        if (cand_ok || (retry_q == RETRY_LAST)) begin
          target_d       = cand_ok ? lfsr_value : forced_target;
          prev_target_d  = cand_ok ? lfsr_value : forced_target;
          target_valid_d = 1'b1;
          tgt_cnt_d      = '0;
          state_d        = WAIT_HIT;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      WAIT_HIT: begin
        // A contact takes precedence over a timeout landing on the same cycle.
        if (contact || (tgt_cnt_q == TGT_LAST)) begin
          if (contact && (contact_addr == target_q)) begin
            score_d   = add_sat(score_q);
            hit_d     = 1'b1;
            snd_cnt_d = SND_LOAD;
          end else begin
            score_d = sub_floor(score_q);
            miss_d  = 1'b1;
          end
          target_d       = NO_BOX_A;
          target_valid_d = 1'b0;
          cd_cnt_d       = '0;
          state_d        = COOLDOWN;
        end else begin
          tgt_cnt_d = tgt_cnt_q + TGT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          retry_d = '0;
          state_d = ARM;
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Game clock runs only while playing. Expiry overrides the next state but
    // keeps any score update and pulse decided above for this cycle.
    if (state_q inside {ARM, WAIT_HIT, COOLDOWN}) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        timer_d = timer_q - 7'd1;
        if (timer_q == 7'd1) begin
          state_d        = DONE;
          target_d       = NO_BOX_A;
          target_valid_d = 1'b0;
          snd_cnt_d      = '0;
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      prev_target_q  <= '0;
      score_q        <= '0;
      timer_q        <= TIMER_INIT;
      presc_q        <= '0;
      tgt_cnt_q      <= '0;
      cd_cnt_q       <= '0;
      retry_q        <= '0;
      snd_cnt_q      <= '0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      prev_target_q  <= prev_target_d;
      score_q        <= score_d;
      timer_q        <= timer_d;
      presc_q        <= presc_d;
      tgt_cnt_q      <= tgt_cnt_d;
      cd_cnt_q       <= cd_cnt_d;
      retry_q        <= retry_d;
      snd_cnt_q      <= snd_cnt_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      start_q        <= start_d;
    end
  end

  assign target       = target_q;
  assign target_valid = target_valid_q;
  assign score        = score_q;
  assign game_timer   = timer_q;
  assign game_over    = (state_q == DONE);
  assign hit_event    = hit_q;
  assign miss_event   = miss_q;
  assign play_sound   = (snd_cnt_q != '0);
  assign state_dbg    = state_q;

endmodule
